// File: rtl/nw_pkg.sv
// nw_pkg: direction codes shared with the grid cell writer, and traceback FSM states
package nw_pkg;
    typedef enum logic [1:0] {TOP_DIR = 2'b00, LEFT_DIR = 2'b01, CORNER_DIR = 2'b10, BAD_DIR = 2'b11} dir_e;
    typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DRAIN, DONE} state_e;
endpackage

// File: rtl/nw_char_sel.sv
// nw_char_sel: picks character idx out of a packed string
module nw_char_sel #(
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int IW = $clog2(LENGTH)
)(
    input  logic [LENGTH*CWIDTH-1:0] s,
    input  logic [IW-1:0]            idx,
    output logic [CWIDTH-1:0]        c
);
    assign c = CWIDTH'(s >> (idx * CWIDTH));
endmodule

// File: rtl/nw_traceback.sv
// nw_traceback: walks the NW direction RAM from the far corner back to (0,0)
// and streams one alignment column op per handshake, last column first.
module nw_traceback
    import nw_pkg::*;
#(
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int IW = $clog2(LENGTH)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    output logic                     dir_rd_en,
    output logic [IW-1:0]            dir_row,
    output logic [IW-1:0]            dir_col,
    input  logic [1:0]               dir_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_op,
    output logic [CWIDTH-1:0]        out_c1,
    output logic [CWIDTH-1:0]        out_c2,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    state_e                  state;
    logic [LENGTH*CWIDTH-1:0] s1_q, s2_q;
    logic [IW-1:0]           j, k, j_n, k_n;
    logic                    row_out, col_out, row_out_n, col_out_n;
    logic                    row_step, col_step, fire;
    logic [1:0]              op_w;
    logic [CWIDTH-1:0]       c1, c2;
    // In WAIT the op under evaluation is the fresh RAM word, otherwise the one being presented
    assign op_w      = state == WAIT ? dir_rdata : out_op;
    assign row_step  = op_w != LEFT_DIR;
    assign col_step  = op_w != TOP_DIR;
    assign row_out_n = row_out | (row_step && j == '0);
    assign col_out_n = col_out | (col_step && k == '0);
    assign j_n       = row_step && j != '0 ? j - IW'(1) : j;
    assign k_n       = col_step && k != '0 ? k - IW'(1) : k;
    assign fire      = out_valid && out_ready;
    assign dir_row   = j;
    assign dir_col   = k;
    nw_char_sel #(.LENGTH(LENGTH), .CWIDTH(CWIDTH), .IW(IW)) u_sel1 (
        .s(s1_q), .idx(state == WAIT ? j : j_n), .c(c1)
    );
    nw_char_sel #(.LENGTH(LENGTH), .CWIDTH(CWIDTH), .IW(IW)) u_sel2 (
        .s(s2_q), .idx(state == WAIT ? k : k_n), .c(c2)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            j         <= '0;
            k         <= '0;
            row_out   <= 1'b0;
            col_out   <= 1'b0;
            dir_rd_en <= 1'b0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_c1    <= '0;
            out_c2    <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            dir_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    s1_q      <= s1;
                    s2_q      <= s2;
                    j         <= IW'(LENGTH - 1);
                    k         <= IW'(LENGTH - 1);
                    row_out   <= 1'b0;
                    col_out   <= 1'b0;
                    error     <= 1'b0;
                    busy      <= 1'b1;
                    dir_rd_en <= 1'b1;
                    state     <= READ;
                end
                READ: state <= WAIT;
                WAIT: if (dir_rdata == BAD_DIR) begin
                    error <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    out_valid <= 1'b1;
                    out_op    <= dir_rdata;
                    out_c1    <= row_step ? c1 : '0;
                    out_c2    <= col_step ? c2 : '0;
                    out_last  <= row_out_n && col_out_n;
                    state     <= EMIT;
                end
                EMIT, DRAIN: if (fire) begin
                    j         <= j_n;
                    k         <= k_n;
                    row_out   <= row_out_n;
                    col_out   <= col_out_n;
                    // Exactly one index exhausted: keep streaming the other axis without RAM reads
                    out_valid <= row_out_n ^ col_out_n;
                    out_op    <= row_out_n ? LEFT_DIR : TOP_DIR;
                    out_c1    <= row_out_n ? '0 : c1;
                    out_c2    <= row_out_n ? c2 : '0;
                    out_last  <= row_out_n ? k_n == '0 : j_n == '0;
                    dir_rd_en <= !(row_out_n || col_out_n);
                    busy      <= !(row_out_n && col_out_n);
                    done      <= row_out_n && col_out_n;
                    state     <= row_out_n && col_out_n ? DONE : (row_out_n || col_out_n) ? DRAIN : READ;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nw_traceback.sv
// tb_nw_traceback: directed traceback runs on a 4x4 grid against a queue of
// hand-computed column ops, checked by an independent output monitor.
module tb_nw_traceback;
    import nw_pkg::*;
    localparam int L = 4, CW = 2, IW = 2;
    localparam logic [L*CW-1:0] ACGT = 8'hE4, TGCA = 8'h1B;
    typedef struct packed {logic [1:0] op; logic [CW-1:0] c1; logic [CW-1:0] c2; logic last;} op_t;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [L*CW-1:0] s1 = ACGT, s2 = ACGT;
    logic dir_rd_en, out_valid, out_last, busy, done, error;
    logic [IW-1:0] dir_row, dir_col;
    logic [1:0] dir_rdata = 2'b00, out_op;
    logic [CW-1:0] out_c1, out_c2;
    logic out_ready = 1'b1, tog_en = 1'b0, ready_lvl = 1'b1;
    logic [3:0] pat = 4'b1001;
    logic [1:0] pi = 2'd0;
    logic [1:0] ram [L][L];
    op_t exp_q[$];
    op_t held;
    logic stall_q = 1'b0;
    int total = 0, bad = 0, cyc = 0, pops = 0, last_pop_cyc = -10;

    nw_traceback #(.LENGTH(L), .CWIDTH(CW), .IW(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .dir_rd_en(dir_rd_en), .dir_row(dir_row), .dir_col(dir_col), .dir_rdata(dir_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_c1(out_c1),
        .out_c2(out_c2), .out_last(out_last), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (dir_rd_en) dir_rdata <= ram[dir_row][dir_col];
    always @(posedge clk) begin
        #1;
        out_ready = tog_en ? pat[pi] : ready_lvl;
        pi = pi + 2'd1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per handshake and checks that stalled ops stay put
    always @(negedge clk) begin
        op_t cur, e;
        if (reset) begin
            cur = {out_op, out_c1, out_c2, out_last};
            if (stall_q) check("stall_hold", 32'(cur), 32'(held));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_op: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("op", 32'(cur), 32'(e));
                end
                pops++;
                last_pop_cyc = cyc;
            end
            stall_q = out_valid && !out_ready;
            held = cur;
        end else stall_q = 1'b0;
    end

    task automatic push(logic [1:0] op, logic [CW-1:0] c1, logic [CW-1:0] c2, logic last);
        exp_q.push_back({op, c1, c2, last});
    endtask

    task automatic push_corner();
        push(CORNER_DIR, 2'd3, 2'd3, 1'b0);
        push(CORNER_DIR, 2'd2, 2'd2, 1'b0);
        push(CORNER_DIR, 2'd1, 2'd1, 1'b0);
        push(CORNER_DIR, 2'd0, 2'd0, 1'b1);
    endtask

    task automatic fill(logic [1:0] d);
        for (int r = 0; r < L; r++) for (int c = 0; c < L; c++) ram[r][c] = d;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 300);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: no done within %0d cycles", name, n);
        end
    endtask

    task automatic run(string name, bit restart);
        pulse_start();
        check({name, "_busy_on"}, 32'(busy), 1);
        check({name, "_err_clr"}, 32'(error), 0);
        if (restart) begin
            repeat (3) @(posedge clk);
            #1 s1 = TGCA; s2 = 8'h00; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(name);
        check({name, "_done_lat"}, 32'(cyc - last_pop_cyc), 1);
        check({name, "_busy_off"}, 32'(busy), 0);
        check({name, "_left"}, 32'(exp_q.size()), 0);
        @(negedge clk);
        check({name, "_pulse"}, 32'(done), 0);
        s1 = ACGT;
        s2 = ACGT;
    endtask

    initial begin
        int n, p0;
        fill(CORNER_DIR);
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({dir_rd_en, dir_row, dir_col, out_valid, out_op, out_c1, out_c2,
                                 out_last, busy, done, error}), 0);
        reset = 1'b1;
        // 1: diagonal path
        push_corner();
        run("t1", 1'b0);
        // 2: mixed path ending in a LEFT drain
        ram[3][3] = TOP_DIR;
        ram[2][3] = TOP_DIR;
        ram[1][3] = CORNER_DIR;
        ram[0][2] = LEFT_DIR;
        s2 = TGCA;
        push(TOP_DIR,    2'd3, 2'd0, 1'b0);
        push(TOP_DIR,    2'd2, 2'd0, 1'b0);
        push(CORNER_DIR, 2'd1, 2'd0, 1'b0);
        push(LEFT_DIR,   2'd0, 2'd1, 1'b0);
        push(CORNER_DIR, 2'd0, 2'd2, 1'b0);
        push(LEFT_DIR,   2'd0, 2'd3, 1'b1);
        p0 = pops;
        run("t2", 1'b0);
        check("t2_ops", 32'(pops - p0), 6);
        fill(CORNER_DIR);
        // 3: back-pressure
        tog_en = 1'b1;
        push_corner();
        run("t3", 1'b0);
        tog_en = 1'b0;
        // 4: bad direction code
        ram[3][3] = BAD_DIR;
        p0 = pops;
        pulse_start();
        wait_done("t4");
        check("t4_error", 32'(error), 1);
        check("t4_busy", 32'(busy), 0);
        @(negedge clk);
        check("t4_sticky", 32'(error), 1);
        check("t4_no_op", 32'(pops - p0), 0);
        ram[3][3] = CORNER_DIR;
        push_corner();
        run("t4b", 1'b0);
        // 5: reset during the second op
        p0 = pops;
        push_corner();
        pulse_start();
        n = 0;
        while (pops < p0 + 1 && n < 100) begin @(negedge clk); n++; end
        ready_lvl = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("t5_emit2", 32'(out_valid), 1);
        reset = 1'b0;
        #1;
        check("t5_rst_outs", 32'({dir_rd_en, dir_row, dir_col, out_valid, out_op, out_c1, out_c2,
                                  out_last, busy, done, error}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ready_lvl = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_no_done", 32'(done | busy), 0);
        push_corner();
        run("t5", 1'b0);
        // 6: start while busy, with changed strings
        push_corner();
        run("t6", 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
